// File: rtl/adc_fifo_pop_ctrl_if.sv
// rtl/adc_fifo_pop_ctrl_if.sv - FIFO pop-side, DMA stream and burst handshake bundle
interface adc_fifo_pop_ctrl_if;
  logic [3:0]  Fifo_Pop_Flag_i;
  logic [31:0] Fifo_Dout_i;
  logic        Fifo_Pop_o;
  logic        Fifo_Pop_Flush_o;
  logic [31:0] Dat_o;
  logic        Dat_Vld_o;
  logic        Dat_Rdy_i;
  logic        Dma_Req_o;
  logic        Dma_Ack_i;
  logic        Dma_Done_o;

  modport master (
    input  Fifo_Pop_Flag_i, Fifo_Dout_i, Dat_Rdy_i, Dma_Ack_i,
    output Fifo_Pop_o, Fifo_Pop_Flush_o, Dat_o, Dat_Vld_o, Dma_Req_o, Dma_Done_o
  );

  modport slave (
    output Fifo_Pop_Flag_i, Fifo_Dout_i, Dat_Rdy_i, Dma_Ack_i,
    input  Fifo_Pop_o, Fifo_Pop_Flush_o, Dat_o, Dat_Vld_o, Dma_Req_o, Dma_Done_o
  );
endinterface

// File: rtl/adc_fifo_pop_ctrl.sv
// rtl/adc_fifo_pop_ctrl.sv - ADC FIFO read-side burst controller feeding the DMA stream
// Optional delivered-word counter enabled by ADC_FIFO_POP_WCNT_EN.
module adc_fifo_pop_ctrl #(
  parameter int         BURST_LEN   = 16,
  parameter logic [3:0] THRESH_FLAG = 4'h5,
  parameter int         CNT_W       = 16
) (
  input  logic                 Pop_Clk,
  input  logic                 Pop_Rst_n,
  input  logic                 Enable_i,
  input  logic                 Flush_i,
  adc_fifo_pop_ctrl_if.master  bus,
  output logic [CNT_W-1:0]     Word_Cnt_o
);

  localparam int             BW         = $clog2(BURST_LEN + 1);
  localparam logic [BW-1:0]  BURST_MAX  = BW'(BURST_LEN);
  localparam logic [BW-1:0]  BURST_LAST = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  state_t        state;
  logic          dma_req;
  logic          dma_done;
  logic          flush_q;
  logic          pop_q;
  logic          pop;
  logic          flush_blk;
  logic          dat_vld;
  logic          xfer_ok;
  logic [BW-1:0] pops_issued;
  logic [BW-1:0] delivered;
  logic [1:0]    buf_cnt;
  logic [31:0]   buf0;
  logic [31:0]   buf1;

  assign flush_blk = Flush_i | flush_q;
  // The word popped last cycle is presented straight from DOUT when the buffer is empty.
  assign dat_vld   = (buf_cnt != 2'd0) | pop_q;
  assign xfer_ok   = dat_vld & bus.Dat_Rdy_i;

  // A flag of 1 with a pop already in flight means that pop took the last word.
  assign pop = (state == XFER) && (bus.Fifo_Pop_Flag_i != 4'h0) &&
               (pops_issued < BURST_MAX) &&
               (({1'b0, buf_cnt} + {2'b00, pop_q}) < 3'd2) &&
               !(pop_q && (bus.Fifo_Pop_Flag_i == 4'h1)) && !flush_blk;

  always_ff @(posedge Pop_Clk or negedge Pop_Rst_n) begin
    if (!Pop_Rst_n) begin
      state       <= IDLE;
      dma_req     <= 1'b0;
      dma_done    <= 1'b0;
      flush_q     <= 1'b0;
      pops_issued <= '0;
      delivered   <= '0;
    end else if (Flush_i) begin
      state       <= IDLE;
      dma_req     <= 1'b0;
      dma_done    <= 1'b0;
      flush_q     <= 1'b1;
      pops_issued <= '0;
      delivered   <= '0;
    end else begin
      flush_q  <= 1'b0;
      dma_done <= 1'b0;
      case (state)
        IDLE: begin
          if (Enable_i && (bus.Fifo_Pop_Flag_i >= THRESH_FLAG)) begin
            state   <= REQ;
            dma_req <= 1'b1;
          end
        end
        REQ: begin
          if (bus.Dma_Ack_i) begin
            state       <= XFER;
            dma_req     <= 1'b0;
            pops_issued <= '0;
            delivered   <= '0;
          end
        end
        XFER: begin
          if (pop) pops_issued <= pops_issued + 1'b1;
          if (xfer_ok) begin
            delivered <= delivered + 1'b1;
            if (delivered == BURST_LAST) begin
              state    <= DONE;
              dma_done <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Pop_Clk or negedge Pop_Rst_n) begin
    if (!Pop_Rst_n) begin
      pop_q   <= 1'b0;
      buf_cnt <= 2'd0;
      buf0    <= '0;
      buf1    <= '0;
    end else if (Flush_i) begin
      pop_q   <= 1'b0;
      buf_cnt <= 2'd0;
    end else begin
      pop_q <= pop;
      case (buf_cnt)
        2'd0: begin
          if (pop_q && !xfer_ok) begin
            buf0    <= bus.Fifo_Dout_i;
            buf_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (xfer_ok) begin
            if (pop_q) buf0    <= bus.Fifo_Dout_i;
            else       buf_cnt <= 2'd0;
          end else if (pop_q) begin
            buf1    <= bus.Fifo_Dout_i;
            buf_cnt <= 2'd2;
          end
        end
        default: begin
          if (xfer_ok) begin
            buf0 <= buf1;
            if (pop_q) buf1    <= bus.Fifo_Dout_i;
            else       buf_cnt <= 2'd1;
          end
        end
      endcase
    end
  end

  assign bus.Fifo_Pop_o       = pop;
  assign bus.Fifo_Pop_Flush_o = flush_q;
  assign bus.Dat_Vld_o        = dat_vld;
  assign bus.Dat_o            = (buf_cnt != 2'd0) ? buf0 : (pop_q ? bus.Fifo_Dout_i : 32'd0);
  assign bus.Dma_Req_o        = dma_req;
  assign bus.Dma_Done_o       = dma_done;

`ifdef ADC_FIFO_POP_WCNT_EN
  logic [CNT_W-1:0] word_cnt;

  always_ff @(posedge Pop_Clk or negedge Pop_Rst_n) begin
    if (!Pop_Rst_n)   word_cnt <= '0;
    else if (xfer_ok) word_cnt <= word_cnt + 1'b1;
  end

  assign Word_Cnt_o = word_cnt;
`else
  assign Word_Cnt_o = '0;
`endif

endmodule

// File: tb/tb_adc_fifo_pop_ctrl.sv
// tb/tb_adc_fifo_pop_ctrl.sv - directed bench for adc_fifo_pop_ctrl with a lagging-flag FIFO model
module tb_adc_fifo_pop_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] word_cnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  adc_fifo_pop_ctrl_if bus ();

  adc_fifo_pop_ctrl #(.BURST_LEN(16), .THRESH_FLAG(4'h5), .CNT_W(16)) dut (
    .Pop_Clk    (clk),
    .Pop_Rst_n  (rst_n),
    .Enable_i   (enable),
    .Flush_i    (flush),
    .bus        (bus),
    .Word_Cnt_o (word_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: registered DOUT, flag code registered from the pre-pop count (one cycle stale).
  logic [31:0] mem [0:511];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          underflow = 0;
  logic [31:0] dout = '0;
  logic [3:0]  flag_reg = '0;
  logic        force_en = 1'b0;
  logic [3:0]  force_val = '0;

  function automatic logic [3:0] flag_code(input int n);
    int m;
    logic [3:0] c;
    m = n;
    if (m <= 0) return 4'h0;
    c = 4'h1;
    while (m >= 2 && c < 4'hf) begin
      m = m >> 1;
      c = c + 4'h1;
    end
    return c;
  endfunction

  always @(posedge clk) begin
    flag_reg <= flag_code(wr_ptr - rd_ptr);
    if (!rst_n || bus.Fifo_Pop_Flush_o) begin
      rd_ptr <= wr_ptr;
    end else if (bus.Fifo_Pop_o) begin
      if (wr_ptr == rd_ptr) underflow <= underflow + 1;
      dout   <= mem[rd_ptr % 512];
      rd_ptr <= rd_ptr + 1;
    end
  end

  assign bus.Fifo_Pop_Flag_i = force_en ? force_val : flag_reg;
  assign bus.Fifo_Dout_i     = dout;

  task automatic push(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % 512] = base + i;
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stream monitor, sampled mid-cycle.
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          first_tx = 0;
  int          last_tx = 0;
  int          pops_total = 0;
  int          tx_total = 0;
  int          out_base = 0;
  int          max_out = 0;
  int          bad_pop = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_dat = '0;
  logic [31:0] rx_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.Dat_Vld_o && bus.Dat_Rdy_i) begin
        if (rx_q.size() == 0) first_tx = cyc;
        last_tx = cyc;
        rx_q.push_back(bus.Dat_o);
        tx_total++;
      end
      if (bus.Fifo_Pop_o) pops_total++;
      if (bus.Fifo_Pop_o && bus.Fifo_Pop_Flag_i == 4'h0) bad_pop++;
      if (bus.Dma_Done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (pops_total - tx_total - out_base > max_out) max_out = pops_total - tx_total - out_base;
      if (stall_prev) check("stall_hold", {31'd0, bus.Dat_Vld_o, bus.Dat_o}, {31'd0, 1'b1, stall_dat});
      stall_prev = bus.Dat_Vld_o && !bus.Dat_Rdy_i;
      stall_dat  = bus.Dat_o;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int i;
    i = 0;
    while (!bus.Dma_Req_o && i < 20) begin
      tick();
      i++;
    end
    check(tag, bus.Dma_Req_o, 1);
  endtask

  task automatic wait_done(input string tag);
    int d0;
    int i;
    d0 = done_cnt;
    i = 0;
    while (done_cnt == d0 && i < 200) begin
      tick();
      i++;
    end
    tick();
    tick();
    check(tag, done_cnt - d0, 1);
  endtask

  task automatic check_data(input string tag, input logic [31:0] base);
    check({tag, "_count"}, rx_q.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < rx_q.size()) check({tag, "_word"}, rx_q[i], base + i);
  endtask

  task automatic run_burst(input string tag, input logic [31:0] base);
    rx_q.delete();
    push(base, 16);
    wait_req({tag, "_req"});
    bus.Dma_Ack_i = 1'b1;
    tick();
    bus.Dma_Ack_i = 1'b0;
    wait_done({tag, "_done"});
    check_data(tag, base);
  endtask

  initial begin
    int ack_cyc;
    int pop_base;
    int d0;
    int i;
    bus.Dat_Rdy_i = 1'b1;
    bus.Dma_Ack_i = 1'b0;

    // reset state
    tick();
    @(negedge clk);
    check("rst_req", bus.Dma_Req_o, 0);
    check("rst_pop", bus.Fifo_Pop_o, 0);
    check("rst_flush", bus.Fifo_Pop_Flush_o, 0);
    check("rst_vld", bus.Dat_Vld_o, 0);
    check("rst_dat", bus.Dat_o, 0);
    check("rst_done", bus.Dma_Done_o, 0);
    check("rst_wcnt", word_cnt, 0);
    tick();
    rst_n  = 1'b1;
    enable = 1'b1;
    tick();

    // ack outside REQ is ignored
    bus.Dma_Ack_i = 1'b1;
    tick();
    bus.Dma_Ack_i = 1'b0;
    @(negedge clk);
    check("stray_ack_pop", bus.Fifo_Pop_o, 0);

    // threshold: 15 words -> code 4, no request; 16th -> code 5
    push(32'h100, 15);
    repeat (4) tick();
    @(negedge clk);
    check("thresh4_req", bus.Dma_Req_o, 0);
    push(32'h10f, 1);
    tick();
    @(negedge clk);
    check("thresh5_flag_cycle_req", bus.Dma_Req_o, 0);
    tick();
    @(negedge clk);
    check("thresh5_req", bus.Dma_Req_o, 1);

    // burst 1: latency and back-to-back delivery
    rx_q.delete();
    bus.Dma_Ack_i = 1'b1;
    ack_cyc = cyc;
    tick();
    bus.Dma_Ack_i = 1'b0;
    @(negedge clk);
    check("lat_pop", bus.Fifo_Pop_o, 1);
    check("lat_vld0", bus.Dat_Vld_o, 0);
    check("lat_req_drop", bus.Dma_Req_o, 0);
    tick();
    @(negedge clk);
    check("lat_vld1", bus.Dat_Vld_o, 1);
    check("lat_dat", bus.Dat_o, 32'h100);
    wait_done("b1_done");
    check("b1_first_cyc", first_tx, ack_cyc + 2);
    check("b1_last_cyc", last_tx, ack_cyc + 17);
    check("b1_done_cyc", done_cyc, ack_cyc + 18);
    check_data("b1", 32'h100);

    // burst 2: ready toggling every cycle
    rx_q.delete();
    push(32'h200, 16);
    wait_req("b2_req");
    out_base = pops_total - tx_total;
    max_out  = 0;
    bus.Dma_Ack_i = 1'b1;
    tick();
    bus.Dma_Ack_i = 1'b0;
    d0 = done_cnt;
    i = 0;
    while (done_cnt == d0 && i < 200) begin
      bus.Dat_Rdy_i = ~bus.Dat_Rdy_i;
      tick();
      i++;
    end
    bus.Dat_Rdy_i = 1'b1;
    tick();
    tick();
    check("b2_done", done_cnt - d0, 1);
    check("b2_max_outstanding", (max_out <= 2), 1);
    check_data("b2", 32'h200);

    // burst 3: FIFO holds 3 words, runs empty, refilled with 13; Enable dropped mid-burst
    rx_q.delete();
    push(32'h300, 3);
    repeat (3) tick();
    force_en  = 1'b1;
    force_val = 4'h5;
    wait_req("b3_req");
    bus.Dma_Ack_i = 1'b1;
    tick();
    bus.Dma_Ack_i = 1'b0;
    force_en = 1'b0;
    enable   = 1'b0;
    pop_base = pops_total;
    d0 = done_cnt;
    repeat (12) tick();
    @(negedge clk);
    check("b3_pops3", pops_total - pop_base, 3);
    check("b3_vld_drop", bus.Dat_Vld_o, 0);
    check("b3_rx3", rx_q.size(), 3);
    check("b3_no_done", done_cnt - d0, 0);
    push(32'h303, 13);
    wait_done("b3_done");
    check_data("b3", 32'h300);
    check("b3_no_underflow", underflow + bad_pop, 0);
    force_en  = 1'b1;
    force_val = 4'h5;
    repeat (3) tick();
    @(negedge clk);
    check("disabled_no_req", bus.Dma_Req_o, 0);
    force_en = 1'b0;
    enable   = 1'b1;
    tick();

    // burst 4: flush while word 7 is presented
    rx_q.delete();
    push(32'h400, 16);
    wait_req("b4_req");
    bus.Dma_Ack_i = 1'b1;
    tick();
    bus.Dma_Ack_i = 1'b0;
    i = 0;
    while (rx_q.size() < 6 && i < 40) begin
      tick();
      i++;
    end
    check("b4_six_words", rx_q.size(), 6);
    d0 = done_cnt;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_pulse", bus.Fifo_Pop_Flush_o, 1);
    check("flush_vld", bus.Dat_Vld_o, 0);
    check("flush_pop_blk", bus.Fifo_Pop_o, 0);
    check("flush_req", bus.Dma_Req_o, 0);
    tick();
    @(negedge clk);
    check("flush_pulse_end", bus.Fifo_Pop_Flush_o, 0);
    check("flush_idle_pop", bus.Fifo_Pop_o, 0);
    repeat (4) tick();
    check("flush_no_done", done_cnt - d0, 0);
    check("flush_idle_req", bus.Dma_Req_o, 0);
    run_burst("b5", 32'h500);

    // reset mid-XFER
    push(32'h600, 16);
    wait_req("b6_req");
    bus.Dma_Ack_i = 1'b1;
    tick();
    bus.Dma_Ack_i = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #2;
    check("arst_vld", bus.Dat_Vld_o, 0);
    check("arst_pop", bus.Fifo_Pop_o, 0);
    check("arst_dat", bus.Dat_o, 0);
    check("arst_req", bus.Dma_Req_o, 0);
    check("arst_done", bus.Dma_Done_o, 0);
    check("arst_wcnt", word_cnt, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    run_burst("b7", 32'h700);
    run_burst("b8", 32'h710);
`ifdef ADC_FIFO_POP_WCNT_EN
    check("word_cnt", word_cnt, 32);
`else
    check("word_cnt", word_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/adc_fifo_pop_ctrl.md
Name: adc_fifo_pop_ctrl

Overview:
Read-side controller for the 512x32 ADC sample FIFO. Watches the FIFO pop-side fill flag and raises a DMA burst request when enough samples are queued. Once the request is acknowledged, it pops exactly one burst of words and delivers them on a valid/ready stream to the DMA engine. Runs entirely in the FIFO pop clock domain; the ADC capture logic owns the push side.

Parameters:
BURST_LEN, 16, words per DMA burst (1..512)
THRESH_FLAG, 4'h5, request a burst when Fifo_Pop_Flag_i >= this code (unsigned compare)
CNT_W, 16, width of the optional delivered-word counter

Ports:
Pop_Clk  in  1  FIFO pop clock; sole clock of the block
Pop_Rst_n  in  1  asynchronous active-low reset
Enable_i  in  1  allows new bursts to start
Flush_i  in  1  synchronous flush request, one-cycle pulse
Fifo_Pop_Flag_i  in  4  FIFO POP_FLAG; 4'h0 = empty, 4'h1 = exactly one word
Fifo_Dout_i  in  32  FIFO DOUT; valid the cycle after a pop
Fifo_Pop_o  out  1  FIFO POP strobe
Fifo_Pop_Flush_o  out  1  FIFO pop-side flush
Dat_o  out  32  stream data
Dat_Vld_o  out  1  stream valid
Dat_Rdy_i  in  1  stream ready
Dma_Req_o  out  1  burst request
Dma_Ack_i  in  1  burst grant
Dma_Done_o  out  1  one-cycle pulse when the burst completes
Word_Cnt_o  out  CNT_W  total words delivered (optional feature)

Behaviour:
- Reset (async, Pop_Rst_n=0): all outputs 0, state IDLE, buffer empty, counters 0.
- States:
  - IDLE: Enable_i && flag >= THRESH_FLAG -> REQ.
  - REQ: Dma_Req_o=1 (registered); on Dma_Ack_i -> XFER, Dma_Req_o drops next cycle.
  - XFER: pop/deliver; when delivered == BURST_LEN -> DONE.
  - DONE: Dma_Done_o=1 for exactly one cycle -> IDLE.
- Fifo_Pop_o (combinational) = XFER && flag!=0 && pops_issued<BURST_LEN && buf_cnt+pop_q<2 && !(pop_q && flag==4'h1) && !flush_blk.
  - The last term prevents a pop on a stale flag after the final word.
- pop_q is Fifo_Pop_o registered. Fifo_Dout_i is captured into a 2-entry output buffer on pop_q.
- Dat_o/Dat_Vld_o are driven from the buffer head. A transfer occurs on Dat_Vld_o && Dat_Rdy_i.
- Dat_o holds stable while Dat_Vld_o=1 && Dat_Rdy_i=0.
- Latency: with Dma_Ack_i sampled at edge N, first Fifo_Pop_o is in cycle N+1 and first Dat_Vld_o in cycle N+2.
- Sustained throughput: 1 word/cycle with Dat_Rdy_i=1 and a non-empty FIFO.
- FIFO runs empty mid-burst: pops stall and Dat_Vld_o deasserts when the buffer drains; the burst resumes when the flag goes non-zero. There is no timeout.
- Enable_i deasserted mid-burst: the current burst completes in full; no new REQ is raised.
- Dma_Ack_i outside REQ is ignored.
- Flush_i (highest priority, any state):
  - next cycle Fifo_Pop_Flush_o=1 for one cycle;
  - buffer, pop_q and burst counters cleared; state -> IDLE; Dma_Req_o=0;
  - no Dma_Done_o pulse;
  - flush_blk suppresses Fifo_Pop_o in the Flush_i cycle and the following cycle.
- Reset or flush mid-burst discards buffered words. Word_Cnt_o is unaffected by flush.

Optional Feature:
ADC_FIFO_POP_WCNT_EN
- Defined: Word_Cnt_o increments by 1 on each stream transfer. It wraps modulo 2^CNT_W and is cleared only by reset.
- Undefined: Word_Cnt_o is tied to 0 and no counter flops are present.

Test Plan:
- Flag=4'h4, Enable_i=1 -> Dma_Req_o stays 0. Flag=4'h5 -> Dma_Req_o=1 next cycle.
- Ack at edge N, Dat_Rdy_i=1, FIFO preloaded with 0x100..0x10F -> 16 words in order from cycle N+2, back-to-back. Dma_Done_o pulses once, the cycle after the 16th transfer.
- Dat_Rdy_i toggled 1/0 every cycle -> at most 2 pops outstanding, no lost/duplicated word, Dat_o stable while stalled, 16 words total.
- FIFO holds 3 words, then flag forced to 4'h0 after the third pop -> exactly 3 pops issued (never a pop while flag==0 or a stale 4'h1), Dat_Vld_o drops. Refill 13 -> burst completes with Dma_Done_o.
- Flush_i during word 7 of a burst -> Fifo_Pop_Flush_o one cycle, Dat_Vld_o=0, state IDLE, no Dma_Done_o. Next burst starts cleanly.
- Pop_Rst_n low mid-XFER -> all outputs 0 immediately. With ADC_FIFO_POP_WCNT_EN, after two full bursts Word_Cnt_o=32.
